seq_mult_stage: RTL and testbench

- Iterative shift-add unsigned multiplier. It forms A*B one multiplier bit per enabled clock and presents the full-width product to the M pipeline register (enable-gated, async-reset DFF) directly downstream.
- It trades latency for area when a combinational multiplier is not affordable.
- The start/busy/done handshake lets the control sequencer pace operands. done drives the downstream register's enable.

---
 rtl/seq_mult_stage.sv | 123 ++++++++++++
 tb/tb_seq_mult_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_stage.sv
// -----------------------------------------------------------------------------
// seq_mult_stage
//
// Iterative shift-add unsigned multiplier. Each enabled clock edge consumes one
// multiplier bit, so a product takes exactly B_WIDTH enabled edges after the
// edge that accepts start. The result is held on `product` for the M pipeline
// register downstream, and `done` serves as that register's enable.
//
// Ports:
//   clk      in   1        clock, rising edge
//   a_rst    in   1        asynchronous reset, active-high
//   ce       in   1        clock enable; when low every register holds
//   start    in   1        request a new multiply (sampled when ce=1 and idle)
//   a_in     in   A_WIDTH  multiplicand, captured with start
//   b_in     in   B_WIDTH  multiplier, captured with start
//   busy     out  1        operation in progress (this is the FSM state)
//   done     out  1        one-enabled-cycle pulse: product valid/updated
//   product  out  P_WIDTH  result; holds until the next completion
//
// Handshake: start is accepted only on an enabled edge while busy=0. That
// edge raises busy. Any start seen while busy=1 is dropped, and nothing is
// queued. The completion edge drops busy, raises done and updates product in
// the same edge. done clears on the next enabled edge. A start on that edge is
// accepted, which gives back-to-back operation. product changes only on a
// completion edge or on reset.
// -----------------------------------------------------------------------------
module seq_mult_stage #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               a_rst,
    input  logic               ce,
    input  logic               start,
    input  logic [A_WIDTH-1:0] a_in,
    input  logic [B_WIDTH-1:0] b_in,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(B_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [P_WIDTH-1:0] acc, acc_nxt;
    logic [P_WIDTH-1:0] mcand, mcand_nxt;
    logic [B_WIDTH-1:0] mult_reg, mult_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [P_WIDTH-1:0] product_nxt;
    logic               done_nxt;
    logic [P_WIDTH-1:0] acc_sum;

    // The partial add for the current iteration. The completion edge loads it
    // straight into product, so the last partial product is included.
    assign acc_sum = acc + (mult_reg[0] ? mcand : '0);

    // busy is the state register itself, which keeps the FSM state visible.
    assign busy = (state == S_BUSY);

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mult_reg <= '0;
            count    <= '0;
            product  <= '0;
            done     <= 1'b0;
        end else if (ce) begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            mcand    <= mcand_nxt;
            mult_reg <= mult_nxt;
            count    <= count_nxt;
            product  <= product_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        mcand_nxt   = mcand;
        mult_nxt    = mult_reg;
        count_nxt   = count;
        product_nxt = product;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mcand_nxt = {{(P_WIDTH - A_WIDTH){1'b0}}, a_in};
                    mult_nxt  = b_in;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_nxt   = acc_sum;
                mcand_nxt = mcand << 1;
                mult_nxt  = mult_reg >> 1;
                count_nxt = count + 1'b1;
                if (count == LAST_CNT) begin
                    product_nxt = acc_sum;
                    done_nxt    = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_mult_stage.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_stage
//
// Directed bench for seq_mult_stage with the default 18x18 configuration.
// Inputs change and outputs are sampled 1 ns after each rising edge. Expected
// values are worked out by hand.
// -----------------------------------------------------------------------------
module tb_seq_mult_stage;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int P_W = 36;
    localparam int LAT = 18;

    logic           clk;
    logic           a_rst;
    logic           ce;
    logic           start;
    logic [A_W-1:0] a_in;
    logic [B_W-1:0] b_in;
    logic           busy;
    logic           done;
    logic [P_W-1:0] product;

    int n_tests;
    int n_fail;

    seq_mult_stage dut (
        .clk     (clk),
        .a_rst   (a_rst),
        .ce      (ce),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present operands with start high for one enabled edge (E0)
    task automatic start_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // count edges after E0 until done, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        if (done !== 1'b1) check("timeout_waiting_done", 64'(done), 64'd1);
    endtask

    task automatic run_mult(input string tag, input logic [A_W-1:0] a,
                            input logic [B_W-1:0] b, input logic [P_W-1:0] exp);
        int cyc;
        start_op(a, b);
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int en_cnt;
        int edges;
        int ce_pat [4] = '{1, 0, 0, 1};

        n_tests = 0;
        n_fail  = 0;
        a_rst   = 1'b1;
        ce      = 1'b1;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;

        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        step();
        step();
        a_rst = 1'b0;
        step();

        // basic 3*5, checking busy/done on every edge
        start_op(18'd3, 18'd5);
        for (int i = 1; i < LAT; i++) begin
            check("basic_busy_during", 64'(busy), 64'd1);
            check("basic_done_during", 64'(done), 64'd0);
            step();
        end
        check("basic_busy_last", 64'(busy), 64'd1);
        step();
        check("basic_done", 64'(done), 64'd1);
        check("basic_busy_clear", 64'(busy), 64'd0);
        check("basic_product", 64'(product), 64'd15);
        step();
        check("basic_done_pulse_end", 64'(done), 64'd0);
        check("basic_product_hold", 64'(product), 64'd15);

        // reset in the middle of a 3*5 operation
        start_op(18'd3, 18'd5);
        for (int i = 0; i < 7; i++) step();
        #2 a_rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", 64'(product), 64'd0);
        step();
        a_rst = 1'b0;
        step();
        check("midrst_no_done", 64'(done), 64'd0);
        run_mult("after_rst", 18'd3, 18'd5, 36'd15);
        step();

        // extremes
        run_mult("max", 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001);
        step();
        run_mult("zero_a", 18'd0, 18'h2AAAA, 36'd0);
        step();

        // clock enable: edges after E0 follow the 1,0,0,1 pattern
        start_op(18'd100, 18'd200);
        en_cnt = 0;
        edges  = 0;
        while (en_cnt < LAT && edges < 100) begin
            ce = ce_pat[edges % 4][0];
            step();
            edges++;
            if (ce) en_cnt++;
            if (en_cnt < LAT) begin
                check("ce_busy_frozen", 64'(busy), 64'd1);
                check("ce_done_low", 64'(done), 64'd0);
                check("ce_product_frozen", 64'(product), 64'd0);
            end
        end
        check("ce_total_edges", 64'(edges), 64'd36);
        check("ce_done", 64'(done), 64'd1);
        check("ce_product", 64'(product), 64'd20000);
        ce = 1'b0;
        step();
        step();
        check("ce_done_held", 64'(done), 64'd1);
        check("ce_busy_held", 64'(busy), 64'd0);
        check("ce_product_held", 64'(product), 64'd20000);
        ce = 1'b1;
        step();
        check("ce_done_cleared", 64'(done), 64'd0);

        // start while busy is ignored
        start_op(18'd7, 18'd6);
        step();
        step();
        a_in  = 18'd9;
        b_in  = 18'd9;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        wait_done(cyc);
        check("hs_ignore_latency", 64'(cyc + 4), 64'(LAT));
        check("hs_ignore_product", 64'(product), 64'd42);

        // start accepted in the done cycle
        start_op(18'd11, 18'd13);
        check("b2b_done_drop", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_product_hold", 64'(product), 64'd42);
        for (int i = 1; i < LAT; i++) begin
            check("b2b_hold_during", 64'(product), 64'd42);
            step();
        end
        check("b2b_hold_last", 64'(product), 64'd42);
        step();
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_product", 64'(product), 64'd143);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
